// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: a prescaler steps one digit slot at a time,
// with double-buffered digit data that only changes at a frame boundary.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic [2:0]                bright,
  output logic [7:0]                SEG,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic                      frame_tick
);

  localparam int PW    = $clog2(SCAN_DIV);
  localparam int IW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SLICE = SCAN_DIV / 8;
  localparam logic [PW-1:0] PC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]             pc;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   shadow_data, disp_data;
  logic [NUM_DIGITS-1:0]     shadow_dp, disp_dp;
  logic [NUM_DIGITS-1:0]     shadow_blank, disp_blank;
  logic                      pending;

  logic                      slot_end;
  logic                      frame_end;
  logic [3:0]                cur_nib;
  logic                      cur_dp;
  logic                      cur_blank;
  logic [31:0]               on_limit;
  logic                      lit;
  logic [NUM_DIGITS-1:0]     an_next;
  logic [7:0]                seg_next;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  assign slot_end  = (pc == PC_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_next   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = disp_data[4*i +: 4];
        cur_dp    = disp_dp[i];
        cur_blank = disp_blank[i];
      end
    end
    // Brightness is a duty cycle in eighths of the slot, taken from the live input.
    on_limit = (32'(bright) + 32'd1) * 32'(SLICE);
    lit      = (32'(pc) < on_limit) && !cur_blank;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && (idx == IW'(i))) an_next[i] = 1'b0;
    end
    seg_next = lit ? {~cur_dp, hex7(cur_nib)} : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      idx          <= '0;
      shadow_data  <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      disp_data    <= '0;
      disp_dp      <= '0;
      disp_blank   <= '0;
      pending      <= 1'b0;
      frame_tick   <= 1'b0;
      AN           <= '1;
      SEG          <= 8'hFF;
    end else begin
      pc         <= slot_end ? '0 : pc + PW'(1);
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      frame_tick <= frame_end;
      AN         <= an_next;
      SEG        <= seg_next;
      if (frame_end && pending) begin
        disp_data  <= shadow_data;
        disp_dp    <= shadow_dp;
        disp_blank <= shadow_blank;
        pending    <= 1'b0;
      end
      // A load on the boundary cycle lands after the copy, so it waits one more frame.
      if (load) begin
        shadow_data  <= data_in;
        shadow_dp    <= dp_in;
        shadow_blank <= blank_in;
        pending      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with 4 digits and an 8-cycle slot: cycle-count reference
// model, a table of hex patterns and hand sequences for frame-boundary corners.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int SD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [15:0]   data_in;
  logic [3:0]    dp_in;
  logic [3:0]    blank_in;
  logic [2:0]    bright;
  logic [7:0]    SEG;
  logic [3:0]    AN;
  logic          frame_tick;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
    .blank_in(blank_in), .bright(bright), .SEG(SEG), .AN(AN), .frame_tick(frame_tick)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: position in the frame comes from cycles elapsed since reset.
  int          m_cyc;
  logic [15:0] sh_d, dis_d;
  logic [3:0]  sh_dp, dis_dp, sh_bl, dis_bl;
  bit          m_pend;
  bit          prev_ft;
  logic [6:0]  hex_tab [16];
  logic [12:0] exp_q [$];

  typedef struct {
    logic [3:0] nib;
    logic       dp;
    logic [7:0] seg;
  } hex_vec_t;
  hex_vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [12:0] e;
    int pc, idx;
    bit lit;
    if (rst) begin
      e = {1'b0, 4'hF, 8'hFF};
      m_cyc = 0; sh_d = '0; sh_dp = '0; sh_bl = '0;
      dis_d = '0; dis_dp = '0; dis_bl = '0; m_pend = 0;
    end else begin
      pc  = m_cyc % SD;
      idx = (m_cyc / SD) % ND;
      lit = (pc < (int'(bright) + 1) * (SD / 8)) && !dis_bl[idx];
      e[12]   = (pc == SD - 1) && (idx == ND - 1);
      e[11:8] = lit ? ~(4'b0001 << idx) : 4'hF;
      e[7:0]  = lit ? {~dis_dp[idx], hex_tab[dis_d[idx*4 +: 4]]} : 8'hFF;
      if (e[12] && m_pend) begin
        dis_d = sh_d; dis_dp = sh_dp; dis_bl = sh_bl; m_pend = 0;
      end
      if (load) begin
        sh_d = data_in; sh_dp = dp_in; sh_bl = blank_in; m_pend = 1;
      end
      m_cyc++;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("an", 32'(AN), 32'(e[11:8]));
    chk("seg", 32'(SEG), 32'(e[7:0]));
    chk("frame_tick", 32'(frame_tick), 32'(e[12]));
    chk("an_onehot", 32'($countones(~AN) <= 1), 32'd1);
    chk("ft_width", 32'(frame_tick && prev_ft), 32'd0);
    prev_ft = frame_tick;
  endtask

  task automatic wait_ft(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_tick && n < 40);
    chk("ft_timeout", 32'(frame_tick), 32'd1);
  endtask

  // segs = {digit3, digit2, digit1, digit0}; checks the first cycle of each slot.
  task automatic check_frame(input bit wait_first, input logic [31:0] segs);
    int n;
    if (wait_first) wait_ft(n);
    for (int d = 0; d < ND; d++) begin
      if (d == 0) tick();
      else for (int k = 0; k < SD; k++) tick();
      chk("frame_seg", 32'(SEG), 32'(segs[d*8 +: 8]));
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic count_lit(input int expd0, input int expd1, input int expd2, input int expd3,
                           input string name);
    int cnt [4];
    int ex [4];
    ex[0] = expd0; ex[1] = expd1; ex[2] = expd2; ex[3] = expd3;
    for (int d = 0; d < ND; d++) cnt[d] = 0;
    for (int k = 0; k < ND * SD; k++) begin
      tick();
      for (int d = 0; d < ND; d++) if (AN[d] == 1'b0) cnt[d]++;
    end
    for (int d = 0; d < ND; d++) chk(name, 32'(cnt[d]), 32'(ex[d]));
  endtask

  initial begin
    int n, ftc;
    logic [3:0] an_seq [4];
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0]  = '{4'h0, 1'b0, 8'hC0};  vecs[1]  = '{4'h1, 1'b1, 8'h79};
    vecs[2]  = '{4'h2, 1'b0, 8'hA4};  vecs[3]  = '{4'h3, 1'b0, 8'hB0};
    vecs[4]  = '{4'h4, 1'b1, 8'h19};  vecs[5]  = '{4'h5, 1'b0, 8'h92};
    vecs[6]  = '{4'h6, 1'b0, 8'h82};  vecs[7]  = '{4'h7, 1'b1, 8'h78};
    vecs[8]  = '{4'h8, 1'b0, 8'h80};  vecs[9]  = '{4'h9, 1'b0, 8'h90};
    vecs[10] = '{4'hA, 1'b0, 8'h88};  vecs[11] = '{4'hB, 1'b1, 8'h03};
    vecs[12] = '{4'hC, 1'b0, 8'hC6};  vecs[13] = '{4'hD, 1'b0, 8'hA1};
    vecs[14] = '{4'hE, 1'b1, 8'h06};  vecs[15] = '{4'hF, 1'b0, 8'h8E};
    an_seq = '{4'hE, 4'hD, 4'hB, 4'h7};

    // Clock/reset
    rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0; bright = 3'd7;
    m_cyc = 0; prev_ft = 0;
    repeat (3) tick();
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_seg", 32'(SEG), 32'hFF);
    chk("rst_ft", 32'(frame_tick), 32'd0);
    rst = 1'b0;

    // Scan after reset release: AN E,D,B,7 every 8 cycles, all digits "0"
    ftc = 0;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (k % SD == 0) begin
        chk("scan_an", 32'(AN), 32'(an_seq[(k / SD) % ND]));
        chk("scan_seg", 32'(SEG), 32'hC0);
      end
      if (frame_tick) ftc++;
    end
    chk("ft_per_64", 32'(ftc), 32'd2);

    // Mid-frame load shows only after the boundary
    repeat (10) tick();
    do_load(16'h3A71, 4'b0010, 4'b0000);
    check_frame(1'b1, {8'hB0, 8'h88, 8'h78, 8'hF9});

    // Load on the exact boundary cycle appears one frame later
    while (m_cyc % (ND * SD) != ND * SD - 1) tick();
    do_load(16'h5555, 4'b0000, 4'b0000);
    chk("boundary_ft", 32'(frame_tick), 32'd1);
    check_frame(1'b0, {8'hB0, 8'h88, 8'h78, 8'hF9});
    check_frame(1'b1, {8'h92, 8'h92, 8'h92, 8'h92});

    // Two loads in one frame: only the second is shown
    do_load(16'h1111, 4'b0000, 4'b0000);
    do_load(16'h2222, 4'b0000, 4'b0000);
    check_frame(1'b1, {8'hA4, 8'hA4, 8'hA4, 8'hA4});

    // Table of hex patterns with decimal point
    for (int v = 0; v < 16; v++) begin
      if (m_cyc % (ND * SD) == ND * SD - 1) tick();
      do_load({4{vecs[v].nib}}, {4{vecs[v].dp}}, 4'b0000);
      wait_ft(n);
      tick();
      chk("hex_vec", 32'(SEG), 32'(vecs[v].seg));
    end

    // Brightness duty cycles
    bright = 3'd0;
    repeat (ND * SD) tick();
    count_lit(1, 1, 1, 1, "bright0_on");
    bright = 3'd3;
    repeat (ND * SD) tick();
    count_lit(4, 4, 4, 4, "bright3_on");
    bright = 3'd7;

    // Blanked digit 2
    do_load(16'h0000, 4'b0000, 4'b0100);
    wait_ft(n);
    count_lit(8, 8, 0, 8, "blank_on");
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_ft(n);

    // Reset mid-slot with pending, load during reset discarded
    repeat (3) tick();
    do_load(16'hFFFF, 4'b1111, 4'b0000);
    tick();
    rst = 1'b1; load = 1'b1; data_in = 16'h1234;
    tick();
    rst = 1'b0; load = 1'b0;
    chk("midrst_an", 32'(AN), 32'hF);
    chk("midrst_seg", 32'(SEG), 32'hFF);
    wait_ft(n);
    chk("midrst_first_ft", 32'(n), 32'(ND * SD));
    check_frame(1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hC0});
    check_frame(1'b1, {8'hC0, 8'hC0, 8'hC0, 8'hC0});

    // Randomized traffic against the reference model
    for (int k = 0; k < 800; k++) begin
      rst      = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 15) == 0);
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom_range(0, 15));
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      bright   = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
